onehot_digit_monitor: RTL and testbench
=======================================

# onehot_digit_monitor

Receiving end of the decade-counter one-hot bus. It samples the 10-bit one-hot output of a digit counter and encodes it into a BCD digit for the display and time-keeping logic. It checks that the counter advances legally (hold, +1, wrap at MODULUS, or return to 0) and produces a carry pulse on wrap. On a fault it drives the counter's reset line to resynchronise it.

## Interface
- MODULUS, 10: number of legal counter states (2..10); legal indices are 0..MODULUS-1 (6 for tens-of-minutes/seconds digits).
- ERR_HOLD, 2: cycles CNT_RESET is held high during recovery (1..15).
- ACQ_TIMEOUT, 16: cycles without a legal code in ACQUIRE before a fault is declared (2..255).

- CLK  in  1  single clock, rising edge; ONEHOT is synchronous to it.
- RESET_N  in  1  asynchronous, active-low reset.
- ONEHOT  in  10  counter one-hot state; bit i set = state i.
- CLR_ERR  in  1  synchronous clear of sticky ERROR.
- DIGIT  out  4  BCD index of last accepted state.
- VALID  out  1  DIGIT reflects the current counter state.
- CARRY  out  1  one-cycle pulse on wrap MODULUS-1 -> 0.
- ERROR  out  1  sticky fault flag.
- CNT_RESET  out  1  active-high reset to the monitored counter.
- LOCKED  out  1  FSM in TRACK.

## Operation
- Input register Q captures ONEHOT every cycle.
- A code is legal when exactly one bit of Q is set and its index is < MODULUS. Zero-hot, multi-hot, and index >= MODULUS are illegal.
- FSM states: ACQUIRE, TRACK, RECOVER.
- ACQUIRE:
  - VALID=0, LOCKED=0, and a timeout counter increments each cycle.
  - On a legal code: DIGIT <= index, VALID <= 1, go to TRACK, clear the timeout counter.
  - Illegal codes are ignored until the counter reaches ACQ_TIMEOUT-1. At that point ERROR <= 1 and the FSM goes to RECOVER.
- TRACK (LOCKED=1), with new index n and previous DIGIT p:
  - n==p: hold.
  - n==p+1 with p<MODULUS-1: DIGIT <= n.
  - p==MODULUS-1 and n==0: DIGIT <= 0, CARRY=1 for one cycle.
  - n==0 with any other p (external counter reset): DIGIT <= 0, no CARRY.
  - Any other legal jump, or an illegal code: ERROR <= 1, VALID <= 0, go to RECOVER. DIGIT holds its last accepted value.
- RECOVER:
  - CNT_RESET=1 for exactly ERR_HOLD cycles, VALID=0, LOCKED=0.
  - Then go to ACQUIRE with the timeout counter cleared.
- ERROR is sticky. It clears on CLR_ERR or reset. If a set and CLR_ERR occur in the same cycle, the set wins.
- The index encoder returns 0..9, 4 bits. Comparisons use 4-bit unsigned arithmetic with no wrap beyond MODULUS-1.

## Timing
- Reset values: DIGIT=0, VALID=0, CARRY=0, ERROR=0, CNT_RESET=0, LOCKED=0, Q=0, state=ACQUIRE, timeout=0.
- The Q=0 present after reset is handled by the ACQUIRE rules above, so it does not cause an immediate error.
- Latency: ONEHOT present at edge k is in Q after edge k. DIGIT, VALID, CARRY, ERROR, and state update at edge k+1, i.e. two edges from input to output.
- CARRY is high for exactly one cycle per wrap, in the same cycle DIGIT becomes 0.
- CNT_RESET rises on the edge that enters RECOVER and stays high for ERR_HOLD cycles. Legal counter codes are next expected two edges after CNT_RESET falls.
- RESET_N assertion mid-operation forces all outputs to their reset values immediately and asynchronously, including dropping CNT_RESET.
- All outputs are registered; no combinational path from ONEHOT to any output.

## Test plan
- Reset release, ONEHOT=10'b1: after two edges VALID=1, LOCKED=1, DIGIT=0, ERROR=0.
- MODULUS=6, step the one-hot through 0..5 then 0, one step per two cycles:
  - DIGIT follows 0,1,2,3,4,5,0.
  - CARRY high exactly one cycle, coincident with DIGIT=0.
  - ERROR stays 0.
- MODULUS=10 locked at DIGIT=3, ONEHOT jumps to 10'b1 (external reset): DIGIT=0, CARRY=0, ERROR=0.
- Locked at DIGIT=2, ONEHOT=10'b0000100000 (skip to 5):
  - ERROR=1, VALID=0, DIGIT holds 2.
  - CNT_RESET high for exactly 2 cycles.
  - Then re-lock on 10'b1.
- Illegal codes while locked:
  - ONEHOT=10'b0000000011 (multi-hot) -> RECOVER, ERROR=1.
  - With MODULUS=6, ONEHOT=10'b1000000 (index 6) -> RECOVER, ERROR=1.
- ACQUIRE timeout and ERROR clear:
  - ONEHOT=0 held after reset -> ERROR=1 after 16 cycles, then RECOVER.
  - CLR_ERR=1 in the same cycle as a new fault -> ERROR remains 1.
  - CLR_ERR=1 alone -> ERROR=0.
  - RESET_N low during RECOVER -> CNT_RESET=0 and all outputs reset immediately.

Source files
------------

// File: rtl/onehot_digit_monitor.sv
// Monitors a decade-counter one-hot bus: encodes it to BCD, checks legal advance,
// pulses CARRY on wrap and drives CNT_RESET to resynchronise the counter on a fault.
module onehot_digit_monitor #(
   parameter int MODULUS     = 10,
   parameter int ERR_HOLD    = 2,
   parameter int ACQ_TIMEOUT = 16
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [9:0] ONEHOT,
   input  logic       CLR_ERR,
   output logic [3:0] DIGIT,
   output logic       VALID,
   output logic       CARRY,
   output logic       ERROR,
   output logic       CNT_RESET,
   output logic       LOCKED
);

   localparam logic [1:0] ST_ACQUIRE = 2'd0;
   localparam logic [1:0] ST_TRACK   = 2'd1;
   localparam logic [1:0] ST_RECOVER = 2'd2;

   localparam logic [3:0] MOD_LAST  = 4'(MODULUS - 1);
   localparam logic [7:0] TMO_LAST  = 8'(ACQ_TIMEOUT - 1);
   localparam logic [3:0] HOLD_INIT = 4'(ERR_HOLD - 1);

   logic [9:0] q_p0;
   logic [1:0] state;
   logic [7:0] tmo;
   logic [3:0] hold_cnt;

   logic [3:0] idx;
   logic       legal;
   logic       n_eq_p, n_inc, n_wrap, n_zero, trk_ok, err_set;

   always_comb begin
      idx = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (q_p0[i]) idx = 4'(i);
      end
      legal = (q_p0 != 10'd0) && ((q_p0 & (q_p0 - 10'd1)) == 10'd0) && (idx <= MOD_LAST);
   end

   // Allowed moves while locked: hold, +1 below the top, wrap from the top, or external reset to 0
   always_comb begin
      n_eq_p  = (idx == DIGIT);
      n_inc   = (idx == DIGIT + 4'd1) && (DIGIT < MOD_LAST);
      n_wrap  = (DIGIT == MOD_LAST) && (idx == 4'd0);
      n_zero  = (idx == 4'd0);
      trk_ok  = legal && (n_eq_p || n_inc || n_wrap || n_zero);
      err_set = ((state == ST_ACQUIRE) && !legal && (tmo == TMO_LAST)) ||
                ((state == ST_TRACK) && !trk_ok);
   end

   // Stage p0: input capture; stage p1: FSM and registered outputs
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         q_p0      <= '0;
         state     <= ST_ACQUIRE;
         tmo       <= '0;
         hold_cnt  <= '0;
         DIGIT     <= '0;
         VALID     <= 1'b0;
         CARRY     <= 1'b0;
         ERROR     <= 1'b0;
         CNT_RESET <= 1'b0;
         LOCKED    <= 1'b0;
      end else begin
         q_p0  <= ONEHOT;
         CARRY <= 1'b0;
         ERROR <= err_set | (ERROR & ~CLR_ERR);
         case (state)
            ST_ACQUIRE: begin
               if (legal) begin
                  DIGIT  <= idx;
                  VALID  <= 1'b1;
                  LOCKED <= 1'b1;
                  state  <= ST_TRACK;
                  tmo    <= '0;
               end else if (tmo == TMO_LAST) begin
                  state     <= ST_RECOVER;
                  CNT_RESET <= 1'b1;
                  hold_cnt  <= HOLD_INIT;
                  VALID     <= 1'b0;
                  LOCKED    <= 1'b0;
               end else begin
                  tmo <= tmo + 8'd1;
               end
            end
            ST_TRACK: begin
               if (!trk_ok) begin
                  state     <= ST_RECOVER;
                  CNT_RESET <= 1'b1;
                  hold_cnt  <= HOLD_INIT;
                  VALID     <= 1'b0;
                  LOCKED    <= 1'b0;
               end else if (!n_eq_p) begin
                  DIGIT <= idx;
                  CARRY <= n_wrap;
               end
            end
            ST_RECOVER: begin
               if (hold_cnt == 4'd0) begin
                  CNT_RESET <= 1'b0;
                  state     <= ST_ACQUIRE;
                  tmo       <= '0;
               end else begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end
            default: state <= ST_ACQUIRE;
         endcase
      end
   end

endmodule

// File: tb/tb_onehot_digit_monitor.sv
// Directed bench for onehot_digit_monitor: one MODULUS=10 and one MODULUS=6 instance.
module tb_onehot_digit_monitor;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic       CLR_ERR;
   logic [9:0] oh10, oh6;

   logic [3:0] d10_digit, d6_digit;
   logic       d10_valid, d10_carry, d10_error, d10_cntrst, d10_locked;
   logic       d6_valid, d6_carry, d6_error, d6_cntrst, d6_locked;

   int nvec = 0;
   int nmis = 0;

   always #5 CLK = ~CLK;

   onehot_digit_monitor #(.MODULUS(10), .ERR_HOLD(2), .ACQ_TIMEOUT(16)) u_dut10 (
      .CLK(CLK), .RESET_N(RESET_N), .ONEHOT(oh10), .CLR_ERR(CLR_ERR),
      .DIGIT(d10_digit), .VALID(d10_valid), .CARRY(d10_carry), .ERROR(d10_error),
      .CNT_RESET(d10_cntrst), .LOCKED(d10_locked)
   );

   onehot_digit_monitor #(.MODULUS(6), .ERR_HOLD(2), .ACQ_TIMEOUT(16)) u_dut6 (
      .CLK(CLK), .RESET_N(RESET_N), .ONEHOT(oh6), .CLR_ERR(CLR_ERR),
      .DIGIT(d6_digit), .VALID(d6_valid), .CARRY(d6_carry), .ERROR(d6_error),
      .CNT_RESET(d6_cntrst), .LOCKED(d6_locked)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      RESET_N = 1'b0;
      CLR_ERR = 1'b0;
      oh10    = 10'b1;
      oh6     = 10'b1;
      tick();
      tick();
      chk("rst d10 digit",  d10_digit, 0);
      chk("rst d10 valid",  d10_valid, 0);
      chk("rst d10 locked", d10_locked, 0);
      chk("rst d10 cntrst", d10_cntrst, 0);
      chk("rst d10 error",  d10_error, 0);
      chk("rst d6 valid",   d6_valid, 0);

      // lock on state 0
      RESET_N = 1'b1;
      tick();
      chk("acq d10 valid early", d10_valid, 0);
      tick();
      chk("lock d10 valid",  d10_valid, 1);
      chk("lock d10 locked", d10_locked, 1);
      chk("lock d10 digit",  d10_digit, 0);
      chk("lock d10 error",  d10_error, 0);
      chk("lock d6 locked",  d6_locked, 1);

      // MODULUS=6 count 1..5 then wrap
      for (int n = 1; n <= 5; n++) begin
         oh6 = 10'b1 << n;
         tick();
         chk("m6 carry mid", d6_carry, 0);
         tick();
         chk("m6 digit", d6_digit, n);
         chk("m6 carry", d6_carry, 0);
         chk("m6 error", d6_error, 0);
      end
      oh6 = 10'b1;
      tick();
      chk("m6 wrap pre digit", d6_digit, 5);
      tick();
      chk("m6 wrap digit", d6_digit, 0);
      chk("m6 wrap carry", d6_carry, 1);
      tick();
      chk("m6 carry drop", d6_carry, 0);
      chk("m6 error after wrap", d6_error, 0);
      chk("m6 valid after wrap", d6_valid, 1);

      // MODULUS=10: count to 3, then external reset to 0
      for (int n = 1; n <= 3; n++) begin
         oh10 = 10'b1 << n;
         tick();
         tick();
      end
      chk("ext d10 digit3", d10_digit, 3);
      oh10 = 10'b1;
      tick();
      tick();
      chk("ext d10 digit0", d10_digit, 0);
      chk("ext d10 carry",  d10_carry, 0);
      chk("ext d10 error",  d10_error, 0);
      chk("ext d10 locked", d10_locked, 1);

      // skip 2 -> 5 is a fault
      for (int n = 1; n <= 2; n++) begin
         oh10 = 10'b1 << n;
         tick();
         tick();
      end
      chk("skip d10 digit2", d10_digit, 2);
      oh10 = 10'b0000100000;
      tick();
      chk("skip d10 cntrst pre", d10_cntrst, 0);
      tick();
      chk("skip d10 error",  d10_error, 1);
      chk("skip d10 valid",  d10_valid, 0);
      chk("skip d10 digit",  d10_digit, 2);
      chk("skip d10 cntrst", d10_cntrst, 1);
      chk("skip d10 locked", d10_locked, 0);
      oh10 = 10'b1;
      tick();
      chk("skip d10 cntrst 2nd", d10_cntrst, 1);
      tick();
      chk("skip d10 cntrst fall", d10_cntrst, 0);
      chk("skip d10 valid acq", d10_valid, 0);
      tick();
      chk("relock d10 valid",  d10_valid, 1);
      chk("relock d10 locked", d10_locked, 1);
      chk("relock d10 digit",  d10_digit, 0);
      chk("relock d10 sticky", d10_error, 1);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      chk("clr d10 error", d10_error, 0);

      // multi-hot while locked
      oh10 = 10'b0000000011;
      tick();
      tick();
      chk("multi d10 error",  d10_error, 1);
      chk("multi d10 cntrst", d10_cntrst, 1);
      chk("multi d10 locked", d10_locked, 0);
      oh10 = 10'b1;
      tick();
      tick();
      tick();
      chk("multi d10 relock", d10_locked, 1);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      chk("multi d10 clr", d10_error, 0);

      // index 6 is out of range for MODULUS=6
      oh6 = 10'b1000000;
      tick();
      tick();
      chk("idx6 d6 error",  d6_error, 1);
      chk("idx6 d6 cntrst", d6_cntrst, 1);
      chk("idx6 d6 valid",  d6_valid, 0);
      chk("idx6 d10 error", d10_error, 0);
      oh6 = 10'b1;
      tick();
      tick();
      tick();
      chk("idx6 d6 relock", d6_locked, 1);

      // acquire timeout with coincident clear, then reset during recover
      RESET_N = 1'b0;
      oh10    = 10'b0;
      oh6     = 10'b0;
      #1;
      RESET_N = 1'b1;
      tick();
      for (int k = 2; k <= 15; k++) begin
         tick();
         chk("tmo d10 valid", d10_valid, 0);
      end
      chk("tmo d10 error pre", d10_error, 0);
      chk("tmo d10 cntrst pre", d10_cntrst, 0);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      chk("tmo d10 error set wins", d10_error, 1);
      chk("tmo d10 cntrst", d10_cntrst, 1);
      chk("tmo d10 locked", d10_locked, 0);
      chk("tmo d6 error", d6_error, 1);
      RESET_N = 1'b0;
      #1;
      chk("arst d10 cntrst", d10_cntrst, 0);
      chk("arst d10 error",  d10_error, 0);
      chk("arst d10 digit",  d10_digit, 0);
      chk("arst d6 cntrst",  d6_cntrst, 0);
      chk("arst d6 error",   d6_error, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
